// File: rtl/m6502_bus_pkg.sv
// Shared constants and enums for the m6502 bus responder.
// Vector addresses, open-bus data, FSM and read-source encodings.
package m6502_bus_pkg;

  localparam logic [15:0] VEC_RESET_LO  = 16'hFFFC;
  localparam logic [15:0] VEC_RESET_HI  = 16'hFFFD;
  localparam logic [7:0]  BUS_IDLE_DATA = 8'hFF;

  typedef enum logic {
    IDLE,
    WAIT
  } resp_state_e;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_VLO,
    SRC_VHI,
    SRC_OPEN
  } src_e;

endpackage

// File: rtl/m6502_bus_responder_if.sv
// CPU-side bus bundle between the m6502 core and the responder.
// The master drives requests; the slave returns data and status.
interface m6502_bus_responder_if;

  logic [15:0] addr;
  logic        rd_req;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        ready;
  logic        bus_err;
  logic        err_clr;

  modport master (
    output addr, rd_req, wr_en, wr_data, err_clr,
    input  rd_data, ready, bus_err
  );

  modport slave (
    input  addr, rd_req, wr_en, wr_data, err_clr,
    output rd_data, ready, bus_err
  );

endinterface

// File: rtl/m6502_bus_ram.sv
// Single-port synchronous RAM, registered read, write-first.
// Read data only changes on a read enable so it holds between reads.
module m6502_bus_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    if (re_i) rdata_o <= we_i ? wdata_i : mem[addr_i];
  end

endmodule

// File: rtl/m6502_bus_responder.sv
// Memory-side target for the m6502 CPU bus: RAM, reset vector,
// open-bus decode, programmable read wait states, sticky error flag.
module m6502_bus_responder
  import m6502_bus_pkg::*;
#(
  parameter int          MEM_AW       = 12,
  parameter int          WAIT_STATES  = 0,
  parameter logic [15:0] RESET_VECTOR = 16'hF000
) (
  input logic                    clk,
  input logic                    reset_n,
  m6502_bus_responder_if.slave   bus
);

  localparam logic [16:0] RAM_TOP  = 17'(1) << MEM_AW;
  localparam logic [3:0]  CNT_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  src_e        sel_q, sel_d;
  logic        err_q, err_d;
  src_e        src;
  logic        in_ram;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  ram_rdata;

  assign in_ram = {1'b0, bus.addr} < RAM_TOP;

  always_comb begin
    src = SRC_OPEN;
    priority case (1'b1)
      (bus.addr == VEC_RESET_LO): src = SRC_VLO;
      (bus.addr == VEC_RESET_HI): src = SRC_VHI;
      in_ram:                     src = SRC_RAM;
      default:                    src = SRC_OPEN;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = err_q;
    ram_re  = 1'b0;
    if (bus.err_clr) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          sel_d  = src;
          ram_re = (src == SRC_RAM);
          if (WAIT_STATES != 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        // A new request here is dropped; the in-flight read completes.
        if (bus.rd_req) err_d = 1'b1;
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= SRC_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign ram_we = bus.wr_en && in_ram;

  m6502_bus_ram #(.AW(MEM_AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (bus.addr[MEM_AW-1:0]),
    .wdata_i (bus.wr_data),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    bus.rd_data = 8'h00;
    unique case (sel_q)
      SRC_NONE: bus.rd_data = 8'h00;
      SRC_RAM:  bus.rd_data = ram_rdata;
      SRC_VLO:  bus.rd_data = RESET_VECTOR[7:0];
      SRC_VHI:  bus.rd_data = RESET_VECTOR[15:8];
      SRC_OPEN: bus.rd_data = BUS_IDLE_DATA;
      default:  bus.rd_data = 8'h00;
    endcase
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.bus_err = err_q;

endmodule

// File: tb/tb_m6502_bus_responder.sv
// Scoreboard bench for m6502_bus_responder at 0, 2 and 3 wait states.
// Stimulus pushes expected reads; a negedge monitor pops and compares.
module tb_m6502_bus_responder;

  typedef struct {
    logic [7:0] d;
    int         lat;
    string      nm;
  } exp_t;

  logic clk;
  logic reset_n;

  logic [15:0] addr    [3];
  logic        rd_req  [3];
  logic        wr_en   [3];
  logic [7:0]  wr_data [3];
  logic        err_clr [3];
  logic [7:0]  rdd     [3];
  logic        rdy     [3];
  logic        berr    [3];

  int ws [3] = '{0, 2, 3};

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic pend [3];
  int   lowc [3];

  m6502_bus_responder_if b0 ();
  m6502_bus_responder_if b1 ();
  m6502_bus_responder_if b2 ();

  assign b0.addr = addr[0];
  assign b0.rd_req = rd_req[0];
  assign b0.wr_en = wr_en[0];
  assign b0.wr_data = wr_data[0];
  assign b0.err_clr = err_clr[0];
  assign rdd[0] = b0.rd_data;
  assign rdy[0] = b0.ready;
  assign berr[0] = b0.bus_err;

  assign b1.addr = addr[1];
  assign b1.rd_req = rd_req[1];
  assign b1.wr_en = wr_en[1];
  assign b1.wr_data = wr_data[1];
  assign b1.err_clr = err_clr[1];
  assign rdd[1] = b1.rd_data;
  assign rdy[1] = b1.ready;
  assign berr[1] = b1.bus_err;

  assign b2.addr = addr[2];
  assign b2.rd_req = rd_req[2];
  assign b2.wr_en = wr_en[2];
  assign b2.wr_data = wr_data[2];
  assign b2.err_clr = err_clr[2];
  assign rdd[2] = b2.rd_data;
  assign rdy[2] = b2.ready;
  assign berr[2] = b2.bus_err;

  m6502_bus_responder #(.MEM_AW(12), .WAIT_STATES(0)) u_d0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave));
  m6502_bus_responder #(.MEM_AW(12), .WAIT_STATES(2)) u_d2 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave));
  m6502_bus_responder #(.MEM_AW(12), .WAIT_STATES(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(int k, logic [7:0] d, string nm);
    exp_t e;
    e.d = d;
    e.lat = ws[k];
    e.nm = nm;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(int k, output exp_t e, output bit ok);
    ok = 1'b1;
    e.d = 8'h00;
    e.lat = 0;
    e.nm = "";
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        pend[k] = 1'b0;
        lowc[k] = 0;
      end else begin
        if (pend[k]) begin
          if (rdy[k]) begin
            pop(k, e, ok);
            if (!ok) chk("sb_underflow", 32'd1, 32'd0);
            else begin
              chk({e.nm, "_data"}, 32'(rdd[k]), 32'(e.d));
              chk({e.nm, "_lat"}, 32'(lowc[k]), 32'(e.lat));
            end
            pend[k] = 1'b0;
          end else begin
            lowc[k]++;
            if (lowc[k] > 40) begin
              chk("read_timeout", 32'(lowc[k]), 32'd40);
              pend[k] = 1'b0;
            end
          end
        end
        if (!pend[k] && rd_req[k] && rdy[k]) begin
          pend[k] = 1'b1;
          lowc[k] = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(int k, logic [15:0] a, logic [7:0] d, string nm);
    addr[k] = a;
    rd_req[k] = 1'b1;
    push(k, d, nm);
    cyc();
    rd_req[k] = 1'b0;
  endtask

  task automatic wr(int k, logic [15:0] a, logic [7:0] d);
    addr[k] = a;
    wr_data[k] = d;
    wr_en[k] = 1'b1;
    cyc();
    wr_en[k] = 1'b0;
  endtask

  task automatic wait_idle(int k);
    int n = 0;
    while (!rdy[k] && n < 50) begin
      cyc();
      n++;
    end
    if (!rdy[k]) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 16'h0000;
      rd_req[k] = 1'b0;
      wr_en[k] = 1'b0;
      wr_data[k] = 8'h00;
      err_clr[k] = 1'b0;
      pend[k] = 1'b0;
      lowc[k] = 0;
    end
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(rdy[k]), 32'd1);
      chk("rst_rdata", 32'(rdd[k]), 32'h00);
      chk("rst_err", 32'(berr[k]), 32'd0);
    end

    // reset vector
    rd(0, 16'hFFFC, 8'h00, "vec_lo");
    rd(0, 16'hFFFD, 8'hF0, "vec_hi");
    rd(2, 16'hFFFD, 8'hF0, "vec_hi_ws3");
    wait_idle(2);

    // zero wait states
    wr(0, 16'h0123, 8'h5A);
    rd(0, 16'h0123, 8'h5A, "ws0_ram");

    // three wait states
    wr(2, 16'h0010, 8'hC3);
    rd(2, 16'h0010, 8'hC3, "ws3_ram");
    wait_idle(2);

    // write-first, open bus, no aliasing, vectors not writable
    addr[0] = 16'h0200;
    wr_data[0] = 8'h77;
    wr_en[0] = 1'b1;
    rd_req[0] = 1'b1;
    push(0, 8'h77, "rdwr_same");
    cyc();
    wr_en[0] = 1'b0;
    rd_req[0] = 1'b0;
    wr(0, 16'h0000, 8'hAB);
    wr(0, 16'h2000, 8'h11);
    rd(0, 16'h2000, 8'hFF, "open_bus");
    rd(0, 16'h0000, 8'hAB, "no_alias");
    wr(0, 16'hFFFC, 8'h55);
    rd(0, 16'hFFFC, 8'h00, "vec_ro");
    rd(0, 16'hFFFF, 8'hFF, "open_top");

    // errors on the two-wait-state unit
    wr(1, 16'h0040, 8'h9E);
    rd(1, 16'h0040, 8'h9E, "err_inflight");
    addr[1] = 16'h0041;
    rd_req[1] = 1'b1;
    cyc();
    rd_req[1] = 1'b0;
    chk("err_set", 32'(berr[1]), 32'd1);
    wait_idle(1);
    cyc();
    chk("err_sticky", 32'(berr[1]), 32'd1);
    err_clr[1] = 1'b1;
    cyc();
    err_clr[1] = 1'b0;
    chk("err_clr", 32'(berr[1]), 32'd0);
    rd(1, 16'h0040, 8'h9E, "err_again");
    rd_req[1] = 1'b1;
    err_clr[1] = 1'b1;
    cyc();
    rd_req[1] = 1'b0;
    err_clr[1] = 1'b0;
    chk("err_set_wins", 32'(berr[1]), 32'd1);
    wait_idle(1);
    err_clr[1] = 1'b1;
    cyc();
    err_clr[1] = 1'b0;
    chk("err_clr2", 32'(berr[1]), 32'd0);
    rd(1, 16'h0040, 8'h9E, "wr_in_wait_rd");
    wr(1, 16'h0050, 8'h12);
    wait_idle(1);
    chk("wr_in_wait_noerr", 32'(berr[1]), 32'd0);
    rd(1, 16'h0050, 8'h12, "wr_in_wait_commit");
    wait_idle(1);

    // async reset mid-wait abandons the read
    addr[2] = 16'h0010;
    rd_req[2] = 1'b1;
    cyc();
    rd_req[2] = 1'b0;
    chk("mid_wait_busy", 32'(rdy[2]), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(rdy[2]), 32'd1);
    chk("arst_rdata", 32'(rdd[2]), 32'h00);
    cyc();
    reset_n = 1'b1;
    cyc();
    rd(2, 16'h0010, 8'hC3, "ram_retained");
    wait_idle(2);
    rd(0, 16'h0123, 8'h5A, "ram_retained0");
    cyc();
    cyc();

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
